// File: rtl/pipe_pkg.sv
// Shared types and boundary indices for the pipeline hazard controller.
package pipe_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam int IFID           = 0;
    localparam int IDEX           = 1;
    localparam int EXMEM          = 2;
    localparam int MEMWB          = 3;
    localparam int NUM_BOUNDARIES = 4;

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load still in EX.
module load_use_detect #(
    parameter int LREG_W = 5
) (
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic              ex_need_to_wb,
    input  logic [LREG_W-1:0] ex_rd,
    input  logic              id_valid,
    input  logic [LREG_W-1:0] id_rs1,
    input  logic [LREG_W-1:0] id_rs2,
    input  logic              id_src1_is_reg,
    input  logic              id_src2_is_reg,
    output logic              load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_src1_is_reg & (id_rs1 == ex_rd);
    assign rs2_hit  = id_src2_is_reg & (id_rs2 == ex_rd);
    // x0 is hardwired zero, so a load targeting it creates no dependency
    assign load_use = ex_valid & ex_is_load & ex_need_to_wb & (ex_rd != '0)
                    & id_valid & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall / flush controller with a muldiv handshake FSM.
//   state   | meaning
//   MD_IDLE | no muldiv outstanding; start issued when EX holds a muldiv
//   MD_BUSY | muldiv running, EX held until muldiv_done
//   MD_DONE | result ready but MEM is waiting; unit holds result, no restart
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int LREG_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [LREG_W-1:0] id_rs1,
    input  logic [LREG_W-1:0] id_rs2,
    input  logic              id_src1_is_reg,
    input  logic              id_src2_is_reg,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic              ex_need_to_wb,
    input  logic [LREG_W-1:0] ex_rd,
    input  logic              ex_is_muldiv,
    input  logic              muldiv_done,
    input  logic              redirect_valid,
    input  logic              mem_valid,
    input  logic              mem_req,
    input  logic              mem_ack,
    output logic [3:0]        stall,
    output logic [3:0]        redirect_flush,
    output logic              muldiv_start,
    output logic [CNT_W-1:0]  stall_cycles
);

    md_state_e                 md_state;
    md_state_e                 md_state_nxt;
    logic                      mem_wait;
    logic                      load_use;
    logic                      md_stall;
    logic                      stall_idex;
    logic                      redir;
    logic [1:0]                pend;
    logic [1:0]                pend_nxt;
    logic [NUM_BOUNDARIES-1:0] bubble;

    load_use_detect #(.LREG_W(LREG_W)) u_load_use_detect (
        .ex_valid       (ex_valid),
        .ex_is_load     (ex_is_load),
        .ex_need_to_wb  (ex_need_to_wb),
        .ex_rd          (ex_rd),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_src1_is_reg (id_src1_is_reg),
        .id_src2_is_reg (id_src2_is_reg),
        .load_use       (load_use)
    );

    assign mem_wait = mem_valid & mem_req & ~mem_ack;

    // reset gates the start request so nothing issues or stalls while held
    always_comb begin
        md_state_nxt = md_state;
        muldiv_start = 1'b0;
        md_stall     = 1'b0;
        case (md_state)
            MD_IDLE: begin
                if (ex_valid & ex_is_muldiv & ~reset) begin
                    md_state_nxt = MD_BUSY;
                    muldiv_start = 1'b1;
                    md_stall     = 1'b1;
                end
            end
            MD_BUSY: begin
                if (muldiv_done) begin
                    md_state_nxt = mem_wait ? MD_DONE : MD_IDLE;
                end else begin
                    md_stall = 1'b1;
                end
            end
            MD_DONE: begin
                if (~mem_wait) begin
                    md_state_nxt = MD_IDLE;
                end
            end
            default: md_state_nxt = MD_IDLE;
        endcase
    end

    assign stall_idex = mem_wait | md_stall;
    assign redir      = redirect_valid & ~reset;

    always_comb begin
        stall         = '0;
        stall[MEMWB]  = 1'b0;
        stall[EXMEM]  = mem_wait;
        stall[IDEX]   = stall_idex;
        stall[IFID]   = stall_idex | load_use;

        bubble        = '0;
        bubble[MEMWB] = mem_wait;
        bubble[EXMEM] = md_stall & ~mem_wait;
        bubble[IDEX]  = load_use & ~stall_idex;
        bubble[IFID]  = 1'b0;

        redirect_flush        = '0;
        redirect_flush[IFID]  = bubble[IFID] | redir | pend[IFID];
        redirect_flush[IDEX]  = bubble[IDEX] | redir | pend[IDEX];
        redirect_flush[EXMEM] = bubble[EXMEM];
        redirect_flush[MEMWB] = bubble[MEMWB];
    end

    // a redirect seen while a boundary is held is replayed until it un-stalls
    assign pend_nxt[IFID] = stall[IFID] & (pend[IFID] | redirect_valid);
    assign pend_nxt[IDEX] = stall[IDEX] & (pend[IDEX] | redirect_valid);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            md_state     <= MD_IDLE;
            pend         <= '0;
            stall_cycles <= '0;
        end else begin
            md_state     <= md_state_nxt;
            pend         <= pend_nxt;
            stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, stall[IFID]};
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table, directed corner cases, random vs model.
module tb_pipe_ctrl;

    logic       clock;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_src1_is_reg;
    logic       id_src2_is_reg;
    logic       ex_valid;
    logic       ex_is_load;
    logic       ex_need_to_wb;
    logic [4:0] ex_rd;
    logic       ex_is_muldiv;
    logic       muldiv_done;
    logic       redirect_valid;
    logic       mem_valid;
    logic       mem_req;
    logic       mem_ack;
    logic [3:0] stall, stall4;
    logic [3:0] redirect_flush, redirect_flush4;
    logic       muldiv_start, muldiv_start4;
    logic [31:0] stall_cycles;
    logic [3:0]  stall_cycles4;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_ctrl #(.LREG_W(5), .CNT_W(32)) u_dut (
        .clock(clock), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_src1_is_reg(id_src1_is_reg), .id_src2_is_reg(id_src2_is_reg),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_need_to_wb(ex_need_to_wb),
        .ex_rd(ex_rd), .ex_is_muldiv(ex_is_muldiv), .muldiv_done(muldiv_done),
        .redirect_valid(redirect_valid),
        .mem_valid(mem_valid), .mem_req(mem_req), .mem_ack(mem_ack),
        .stall(stall), .redirect_flush(redirect_flush),
        .muldiv_start(muldiv_start), .stall_cycles(stall_cycles)
    );

    pipe_ctrl #(.LREG_W(5), .CNT_W(4)) u_dut4 (
        .clock(clock), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_src1_is_reg(id_src1_is_reg), .id_src2_is_reg(id_src2_is_reg),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_need_to_wb(ex_need_to_wb),
        .ex_rd(ex_rd), .ex_is_muldiv(ex_is_muldiv), .muldiv_done(muldiv_done),
        .redirect_valid(redirect_valid),
        .mem_valid(mem_valid), .mem_req(mem_req), .mem_ack(mem_ack),
        .stall(stall4), .redirect_flush(redirect_flush4),
        .muldiv_start(muldiv_start4), .stall_cycles(stall_cycles4)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0] mem;   // mem_valid, mem_req, mem_ack
        logic [2:0] ex;    // ex_valid, ex_is_load, ex_need_to_wb
        logic [4:0] rd;
        logic       idv;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] srv;   // src1_is_reg, src2_is_reg, redirect_valid
        logic [3:0] e_stall;
        logic [3:0] e_flush;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic [2:0] mem, input logic [2:0] ex, input logic [4:0] rd,
                                input logic idv, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [2:0] srv, input logic [3:0] es, input logic [3:0] ef);
        vec_t v;
        v.mem = mem; v.ex = ex; v.rd = rd; v.idv = idv; v.rs1 = rs1; v.rs2 = rs2;
        v.srv = srv; v.e_stall = es; v.e_flush = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_src1_is_reg = 0; id_src2_is_reg = 0;
        ex_valid = 0; ex_is_load = 0; ex_need_to_wb = 0; ex_rd = 0; ex_is_muldiv = 0;
        muldiv_done = 0; redirect_valid = 0; mem_valid = 0; mem_req = 0; mem_ack = 0;
    endtask

    task automatic go();
        @(posedge clock);
        #1;
    endtask

    // reference model state: muldiv outstanding / result blocked by MEM, owed redirects
    bit          m_inflight;
    bit          m_blocked;
    bit [1:0]    m_owed;
    logic [31:0] m_count;

    task automatic model_clear();
        m_inflight = 0; m_blocked = 0; m_owed = 0; m_count = 0;
    endtask

    task automatic model_eval(output logic [3:0] e_stall, output logic [3:0] e_flush,
                              output logic e_start, output bit e_mw, output bit e_want);
        bit mw, lu, want, hold, rv;
        mw   = mem_valid && mem_req && !mem_ack;
        lu   = ex_valid && ex_is_load && ex_need_to_wb && (ex_rd != 0) && id_valid &&
               ((id_src1_is_reg && id_rs1 == ex_rd) || (id_src2_is_reg && id_rs2 == ex_rd));
        want = ex_valid && ex_is_muldiv && !m_inflight && !m_blocked && !reset;
        hold = want || (m_inflight && !muldiv_done);
        rv   = redirect_valid && !reset;
        e_stall = {1'b0, mw, mw || hold, mw || hold || lu};
        e_flush = {mw, hold && !mw, (lu && !(mw || hold)) || rv || m_owed[1], rv || m_owed[0]};
        e_start = want;
        e_mw    = mw;
        e_want  = want;
    endtask

    task automatic model_step(input logic [3:0] e_stall, input bit mw, input bit want);
        if (reset) begin
            model_clear();
        end else begin
            if (e_stall[0]) m_count = m_count + 32'd1;
            m_owed[0] = e_stall[0] && (m_owed[0] || redirect_valid);
            m_owed[1] = e_stall[1] && (m_owed[1] || redirect_valid);
            if (want) begin
                m_inflight = 1;
            end else if (m_inflight && muldiv_done) begin
                m_inflight = 0;
                m_blocked  = mw;
            end else if (m_blocked && !mw) begin
                m_blocked = 0;
            end
        end
    endtask

    initial begin
        logic [3:0] es, ef;
        logic       est;
        bit         emw, ewant;

        vecs[0]  = mk(3'b000, 3'b000, 5'd0, 1'b0, 5'd0, 5'd0, 3'b000, 4'b0000, 4'b0000);
        vecs[1]  = mk(3'b000, 3'b111, 5'd5, 1'b1, 5'd5, 5'd0, 3'b100, 4'b0001, 4'b0010);
        vecs[2]  = mk(3'b000, 3'b111, 5'd0, 1'b1, 5'd0, 5'd0, 3'b100, 4'b0000, 4'b0000);
        vecs[3]  = mk(3'b000, 3'b111, 5'd5, 1'b1, 5'd5, 5'd0, 3'b000, 4'b0000, 4'b0000);
        vecs[4]  = mk(3'b000, 3'b111, 5'd5, 1'b1, 5'd0, 5'd5, 3'b010, 4'b0001, 4'b0010);
        vecs[5]  = mk(3'b000, 3'b110, 5'd5, 1'b1, 5'd5, 5'd0, 3'b100, 4'b0000, 4'b0000);
        vecs[6]  = mk(3'b000, 3'b111, 5'd5, 1'b0, 5'd5, 5'd0, 3'b100, 4'b0000, 4'b0000);
        vecs[7]  = mk(3'b110, 3'b000, 5'd0, 1'b0, 5'd0, 5'd0, 3'b000, 4'b0111, 4'b1000);
        vecs[8]  = mk(3'b111, 3'b000, 5'd0, 1'b0, 5'd0, 5'd0, 3'b000, 4'b0000, 4'b0000);
        vecs[9]  = mk(3'b100, 3'b000, 5'd0, 1'b0, 5'd0, 5'd0, 3'b000, 4'b0000, 4'b0000);
        vecs[10] = mk(3'b110, 3'b111, 5'd5, 1'b1, 5'd5, 5'd0, 3'b100, 4'b0111, 4'b1000);
        vecs[11] = mk(3'b000, 3'b000, 5'd0, 1'b0, 5'd0, 5'd0, 3'b001, 4'b0000, 4'b0011);
        vecs[12] = mk(3'b110, 3'b000, 5'd0, 1'b0, 5'd0, 5'd0, 3'b001, 4'b0111, 4'b1011);
        vecs[13] = mk(3'b000, 3'b111, 5'd5, 1'b1, 5'd5, 5'd0, 3'b101, 4'b0001, 4'b0011);
        vecs[14] = mk(3'b000, 3'b101, 5'd5, 1'b1, 5'd5, 5'd0, 3'b100, 4'b0000, 4'b0000);
        vecs[15] = mk(3'b000, 3'b111, 5'd7, 1'b1, 5'd5, 5'd5, 3'b110, 4'b0000, 4'b0000);

        idle_inputs();
        reset = 1'b1;
        go();
        go();
        @(negedge clock);
        check("reset_stall", stall, 4'b0000);
        check("reset_flush", redirect_flush, 4'b0000);
        check("reset_start", muldiv_start, 1'b0);
        check("reset_cnt", stall_cycles, 32'd0);
        go();
        reset = 1'b0;

        // combinational table, each vector followed by two quiet cycles to drain pend
        for (int i = 0; i < NVEC; i++) begin
            {mem_valid, mem_req, mem_ack}         = vecs[i].mem;
            {ex_valid, ex_is_load, ex_need_to_wb} = vecs[i].ex;
            ex_rd    = vecs[i].rd;
            id_valid = vecs[i].idv;
            id_rs1   = vecs[i].rs1;
            id_rs2   = vecs[i].rs2;
            {id_src1_is_reg, id_src2_is_reg, redirect_valid} = vecs[i].srv;
            @(negedge clock);
            check($sformatf("vec%0d_stall", i), stall, vecs[i].e_stall);
            check($sformatf("vec%0d_flush", i), redirect_flush, vecs[i].e_flush);
            go();
            idle_inputs();
            go();
            go();
        end

        // muldiv start, four busy cycles, done on cycle 4
        ex_valid = 1; ex_is_muldiv = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check($sformatf("md_c%0d_start", c), muldiv_start, (c == 0) ? 1'b1 : 1'b0);
            check($sformatf("md_c%0d_stall", c), stall, 4'b0011);
            check($sformatf("md_c%0d_flush", c), redirect_flush, 4'b0100);
            go();
        end
        muldiv_done = 1;
        @(negedge clock);
        check("md_c4_stall", stall, 4'b0000);
        check("md_c4_start", muldiv_start, 1'b0);
        go();
        idle_inputs();
        go();

        // muldiv completes while MEM waits
        ex_valid = 1; ex_is_muldiv = 1;
        @(negedge clock);
        check("mdw_start", muldiv_start, 1'b1);
        go();
        muldiv_done = 1; mem_valid = 1; mem_req = 1;
        @(negedge clock);
        check("mdw_done_stall", stall, 4'b0111);
        go();
        muldiv_done = 0;
        @(negedge clock);
        check("mdw_hold_stall", stall, 4'b0111);
        check("mdw_hold_start", muldiv_start, 1'b0);
        check("mdw_hold_flush", redirect_flush, 4'b1000);
        go();
        mem_ack = 1;
        @(negedge clock);
        check("mdw_ack_stall", stall, 4'b0000);
        check("mdw_ack_start", muldiv_start, 1'b0);
        go();
        idle_inputs();
        go();

        // redirect during a MEM wait is held until the boundary releases
        mem_valid = 1; mem_req = 1; redirect_valid = 1;
        @(negedge clock);
        check("rdw_c0_stall", stall, 4'b0111);
        check("rdw_c0_flush", redirect_flush, 4'b1011);
        go();
        redirect_valid = 0;
        for (int c = 1; c < 3; c++) begin
            @(negedge clock);
            check($sformatf("rdw_c%0d_flush", c), redirect_flush, 4'b1011);
            go();
        end
        mem_ack = 1;
        @(negedge clock);
        check("rdw_ack_stall", stall, 4'b0000);
        check("rdw_ack_flush", redirect_flush, 4'b0011);
        go();
        idle_inputs();
        @(negedge clock);
        check("rdw_after_flush", redirect_flush, 4'b0000);
        go();

        // asynchronous reset in the middle of a muldiv
        ex_valid = 1; ex_is_muldiv = 1;
        @(negedge clock);
        check("rst_md_start", muldiv_start, 1'b1);
        go();
        @(negedge clock);
        check("rst_md_busy_stall", stall, 4'b0011);
        #2;
        reset = 1'b1;
        #1;
        check("rst_md_stall", stall, 4'b0000);
        check("rst_md_cnt", stall_cycles, 32'd0);
        check("rst_md_cnt4", stall_cycles4, 4'd0);
        check("rst_md_start0", muldiv_start, 1'b0);
        go();
        reset = 1'b0;
        @(negedge clock);
        check("rst_md_restart", muldiv_start, 1'b1);
        check("rst_md_restall", stall, 4'b0011);
        go();
        muldiv_done = 1;
        go();
        idle_inputs();
        go();

        // counter wrap: 17 stall cycles
        reset = 1'b1;
        go();
        reset = 1'b0;
        mem_valid = 1; mem_req = 1;
        repeat (17) go();
        idle_inputs();
        @(negedge clock);
        check("wrap_cnt4", stall_cycles4, 4'd1);
        check("wrap_cnt32", stall_cycles, 32'd17);
        go();

        // randomized run against the reference model
        reset = 1'b1;
        model_clear();
        go();
        reset = 1'b0;
        for (int n = 0; n < 600; n++) begin
            reset          = ($urandom_range(0, 59) == 0);
            id_valid       = 1'($urandom_range(0, 1));
            id_rs1         = 5'($urandom_range(0, 3));
            id_rs2         = 5'($urandom_range(0, 3));
            id_src1_is_reg = 1'($urandom_range(0, 1));
            id_src2_is_reg = 1'($urandom_range(0, 1));
            ex_valid       = 1'($urandom_range(0, 1));
            ex_is_load     = 1'($urandom_range(0, 1));
            ex_need_to_wb  = 1'($urandom_range(0, 1));
            ex_rd          = 5'($urandom_range(0, 3));
            ex_is_muldiv   = ($urandom_range(0, 3) == 0);
            muldiv_done    = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            mem_valid      = 1'($urandom_range(0, 1));
            mem_req        = 1'($urandom_range(0, 1));
            mem_ack        = ($urandom_range(0, 2) == 0);
            if (reset) model_clear();
            @(negedge clock);
            model_eval(es, ef, est, emw, ewant);
            check("rnd_stall", stall, es);
            check("rnd_flush", redirect_flush, ef);
            check("rnd_start", muldiv_start, est);
            check("rnd_cnt", stall_cycles, m_count);
            check("rnd_cnt4", stall_cycles4, m_count[3:0]);
            model_step(es, emw, ewant);
            go();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter LREG_W, default 5: logical register index width.
REQ-002 Parameter CNT_W, default 32: stall-cycle counter width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
REQ-004 The block SHALL have these ID-stage inputs:
- id_valid  in  1  ID/EX-bound instruction valid.
- id_rs1, id_rs2  in  LREG_W each  ID source registers.
- id_src1_is_reg, id_src2_is_reg  in  1 each  source reads a register.
REQ-005 The block SHALL have these EX-stage inputs:
- ex_valid  in  1  EX instruction valid.
- ex_is_load  in  1  EX instruction is a load.
- ex_need_to_wb  in  1  EX instruction writes rd.
- ex_rd  in  LREG_W  EX destination.
- ex_is_muldiv  in  1  EX instruction is mul/div.
- muldiv_done  in  1  muldiv result ready (1-cycle pulse).
- redirect_valid  in  1  branch/jump resolved mispredict in EX (1-cycle pulse).
REQ-006 The block SHALL have these MEM-stage inputs:
- mem_valid, mem_req  in  1 each  MEM instruction valid / needs memory.
- mem_ack  in  1  memory response this cycle.
REQ-007 The block SHALL have these outputs:
- stall  out  4  per-boundary hold; bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM, bit3 MEM/WB.
- redirect_flush  out  4  per-boundary clear; a boundary register clears only when flush=1 and stall=0.
- muldiv_start  out  1  one-cycle start pulse to the muldiv unit.
- stall_cycles  out  CNT_W  cycles with stall[0]=1.

Function
REQ-008 mem_wait SHALL equal mem_valid & mem_req & ~mem_ack.
REQ-009 load_use SHALL equal ex_valid & ex_is_load & ex_need_to_wb & (ex_rd!=0) & id_valid & ((id_src1_is_reg & id_rs1==ex_rd) | (id_src2_is_reg & id_rs2==ex_rd)).
REQ-010 The muldiv FSM SHALL have states MD_IDLE, MD_BUSY and MD_DONE, with these transitions:
- MD_IDLE -> MD_BUSY on ex_valid & ex_is_muldiv.
- MD_BUSY -> MD_IDLE on muldiv_done & ~mem_wait.
- MD_BUSY -> MD_DONE on muldiv_done & mem_wait.
- MD_DONE -> MD_IDLE on ~mem_wait.
REQ-011 muldiv_start SHALL be 1 exactly in the MD_IDLE cycle where the MD_IDLE -> MD_BUSY transition fires.
REQ-012 md_stall SHALL equal (MD_IDLE & ex_valid & ex_is_muldiv) | (MD_BUSY & ~muldiv_done).
REQ-013 Stall outputs SHALL be combinational:
- stall[3]=0.
- stall[2]=mem_wait.
- stall[1]=mem_wait|md_stall.
- stall[0]=stall[1]|load_use.
REQ-014 Bubbles SHALL be combinational:
- bubble[3]=mem_wait.
- bubble[2]=md_stall & ~mem_wait.
- bubble[1]=load_use & ~stall[1].
- bubble[0]=0.
REQ-015 For i in {0,1}, redirect_flush[i] SHALL equal bubble[i] | redirect_valid | pend[i]; for i in {2,3}, redirect_flush[i] SHALL equal bubble[i].
REQ-016 pend[i] (i in {0,1}) SHALL be set at posedge when redirect_valid & stall[i], and cleared at posedge when stall[i]=0; set has priority if both apply.
REQ-017 In MD_DONE, no new muldiv_start SHALL issue; the muldiv unit holds its result until the next start.
REQ-018 stall_cycles SHALL increment by 1 per cycle with stall[0]=1 and wrap modulo 2^CNT_W.
REQ-019 Simultaneous load_use and mem_wait SHALL yield stall[1:0]=2'b11 and bubble[1]=0.
REQ-020 A redirect during a stall SHALL never be lost: flush SHALL remain asserted until the target boundary un-stalls.

Reset
REQ-021 On reset, the FSM SHALL go to MD_IDLE, pend SHALL be 0 and stall_cycles SHALL be 0, asynchronously and immediately, including mid-MD_BUSY.
REQ-022 During reset, stall, redirect_flush and muldiv_start SHALL be 0 apart from the combinational mem_wait and load_use terms.

Structure
REQ-023 A shared package pipe_pkg SHALL hold:
- md_state_e enum.
- Boundary indices IFID=0, IDEX=1, EXMEM=2, MEMWB=3.
- NUM_BOUNDARIES=4.
REQ-024 The load-use comparator SHALL be a combinational sub-module load_use_detect; everything else is flat.

Verification
REQ-025 Load-use: ex load rd=5, id rs1=5 src1_is_reg=1 -> stall=4'b0001, redirect_flush=4'b0010 for 1 cycle; with rd=0 -> no stall.
REQ-026 Muldiv: ex_is_muldiv at cycle 0, done at cycle 4 -> muldiv_start=1 at cycle 0 only; stall=4'b0011 and flush[2]=1 for cycles 0-3; at cycle 4 stall=0.
REQ-027 Done under mem_wait: muldiv_done while mem_wait=1 -> state MD_DONE, stall=4'b0111, no restart; mem_ack -> MD_IDLE, stall=0.
REQ-028 Redirect while mem_wait: redirect_valid pulse at stall=4'b0111 -> flush[1:0]=2'b11 held 3 cycles until mem_ack, then 1 more cycle with stall=0, then 0.
REQ-029 Reset mid-MD_BUSY: assert reset -> stall=0 and stall_cycles=0 immediately; after release, same EX muldiv -> fresh muldiv_start.
REQ-030 Counter wrap: CNT_W=4 with 17 stall cycles -> stall_cycles=1.
